// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU request sequencer.
package alu_pkg;

  localparam int OPERAND_W = 16;
  localparam int RESULT_W  = 32;
  localparam int OPCODE_W  = 3;
  localparam int COUNT_W   = 4;

  typedef enum logic [OPCODE_W-1:0] {
    ADD     = 3'b000,
    MUL     = 3'b001,
    SUB     = 3'b010,
    AND     = 3'b011,
    OR      = 3'b100,
    XOR     = 3'b101,
    NOT     = 3'b110,
    ILLEGAL = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_seq_timer.sv
// Down-counter timing the EXEC phase; zero marks the final EXEC cycle.
module alu_seq_timer
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               dec,
  output logic               zero
);

  logic [COUNT_W-1:0] count;

  // Load on acceptance, otherwise count down to zero and stay there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external combinational ALU,
// holding operands stable and returning the sampled result via handshake.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  input  logic [OPCODE_W-1:0]  in_op,
  output logic [OPERAND_W-1:0] alu_a,
  output logic [OPERAND_W-1:0] alu_b,
  output logic [OPCODE_W-1:0]  alu_op,
  input  logic [RESULT_W-1:0]  alu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0]  out_result,
  output logic                out_err
);

  state_t             state;
  state_t             next_state;
  logic               accept;
  logic               is_illegal;
  logic               timer_zero;
  logic [COUNT_W-1:0] timer_load_value;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign is_illegal = (in_op == ILLEGAL);

  // The timer holds the number of EXEC cycles remaining after the current one
  assign timer_load_value = (in_op == MUL) ? COUNT_W'(MUL_CYCLES - 1) : '0;

  alu_seq_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept && !is_illegal),
    .load_value (timer_load_value),
    .dec        (state == EXEC),
    .zero       (timer_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: illegal opcodes bypass EXEC straight to an error response
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = is_illegal ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (timer_zero) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture at acceptance and result capture on the final EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= ADD;
      out_result <= '0;
      out_err    <= 1'b0;
    end else if (accept) begin
      if (is_illegal) begin
        out_result <= '0;
        out_err    <= 1'b1;
      end else begin
        alu_a  <= in_a;
        alu_b  <= in_b;
        alu_op <= in_op;
      end
    end else if ((state == EXEC) && timer_zero) begin
      out_result <= alu_result;
      out_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;

  int check_count;
  int pass_count;

  alu_sequencer #(.MUL_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural downstream ALU, operands zero-extended to 32 bits
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      3'b000:  alu_result = {16'd0, alu_a} + {16'd0, alu_b};
      3'b001:  alu_result = {16'd0, alu_a} * {16'd0, alu_b};
      3'b010:  alu_result = {16'd0, alu_a} - {16'd0, alu_b};
      3'b011:  alu_result = {16'd0, alu_a & alu_b};
      3'b100:  alu_result = {16'd0, alu_a | alu_b};
      3'b101:  alu_result = {16'd0, alu_a ^ alu_b};
      3'b110:  alu_result = ~{16'd0, alu_a};
      default: alu_result = 32'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present a request for one edge; the caller is in the low clock phase
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] op);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count low phases until out_valid; cycle n corresponds to the n-th edge after acceptance
  task automatic waitResponse(input string tag, input int exp_edges,
                              input logic [15:0] exp_a, input logic [15:0] exp_b,
                              input logic [2:0] exp_op);
    int edges;
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        edges = i;
        break;
      end
      checkOutput({tag, "_alu_a_stable"}, {16'd0, alu_a}, {16'd0, exp_a});
      checkOutput({tag, "_alu_b_stable"}, {16'd0, alu_b}, {16'd0, exp_b});
      checkOutput({tag, "_alu_op_stable"}, {29'd0, alu_op}, {29'd0, exp_op});
      checkOutput({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    end
    checkOutput({tag, "_latency"}, edges, exp_edges);
  endtask

  // Accept the response and confirm return to IDLE
  task automatic takeResponse(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_out_valid_cleared"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_a        = 16'd0;
    in_b        = 16'd0;
    in_op       = 3'd0;
    out_ready   = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
    checkOutput("rst_alu_a", {16'd0, alu_a}, 32'd0);
    checkOutput("rst_alu_op", {29'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD 3+4
    applyStimulus(16'd3, 16'd4, 3'b000);
    waitResponse("add", 2, 16'd3, 16'd4, 3'b000);
    checkOutput("add_result", out_result, 32'h0000_0007);
    checkOutput("add_err", {31'd0, out_err}, 32'd0);
    takeResponse("add");

    // MUL 0xFFFF*0xFFFF with two EXEC cycles
    applyStimulus(16'hFFFF, 16'hFFFF, 3'b001);
    waitResponse("mul", 3, 16'hFFFF, 16'hFFFF, 3'b001);
    checkOutput("mul_result", out_result, 32'hFFFE_0001);
    checkOutput("mul_alu_a_done", {16'd0, alu_a}, 32'h0000_FFFF);
    takeResponse("mul");

    // SUB 1-2 then NOT 0x00FF
    applyStimulus(16'd1, 16'd2, 3'b010);
    waitResponse("sub", 2, 16'd1, 16'd2, 3'b010);
    checkOutput("sub_result", out_result, 32'hFFFF_FFFF);
    takeResponse("sub");
    applyStimulus(16'h00FF, 16'h0000, 3'b110);
    waitResponse("not", 2, 16'h00FF, 16'h0000, 3'b110);
    checkOutput("not_result", out_result, 32'hFFFF_FF00);
    takeResponse("not");

    // AND followed by an illegal opcode that must leave the ALU inputs alone
    applyStimulus(16'h0F0F, 16'h00FF, 3'b011);
    waitResponse("and", 2, 16'h0F0F, 16'h00FF, 3'b011);
    checkOutput("and_result", out_result, 32'h0000_000F);
    takeResponse("and");
    applyStimulus(16'h1234, 16'h5678, 3'b111);
    waitResponse("ill", 1, 16'h0F0F, 16'h00FF, 3'b011);
    checkOutput("ill_result", out_result, 32'h0000_0000);
    checkOutput("ill_err", {31'd0, out_err}, 32'd1);
    checkOutput("ill_alu_op", {29'd0, alu_op}, 32'd3);
    checkOutput("ill_alu_a", {16'd0, alu_a}, 32'h0000_0F0F);
    takeResponse("ill");

    // XOR clears out_err after the error response
    applyStimulus(16'hFFFF, 16'h0F0F, 3'b101);
    waitResponse("xor", 2, 16'hFFFF, 16'h0F0F, 3'b101);
    checkOutput("xor_result", out_result, 32'h0000_F0F0);
    checkOutput("xor_err", {31'd0, out_err}, 32'd0);
    takeResponse("xor");

    // OR with back-pressure and a competing request held during DONE
    applyStimulus(16'hA000, 16'h0005, 3'b100);
    waitResponse("or", 2, 16'hA000, 16'h0005, 3'b100);
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_op    = 3'b000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("or_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("or_hold_result", out_result, 32'h0000_A005);
      checkOutput("or_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    checkOutput("or_alu_a_ignored", {16'd0, alu_a}, 32'h0000_A000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("or_idle_after_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("or_no_same_edge_accept", {16'd0, alu_a}, 32'h0000_A000);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("or_still_idle", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a multiply aborts it
    applyStimulus(16'd7, 16'd9, 3'b001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_alu_a", {16'd0, alu_a}, 32'd0);
    checkOutput("abort_alu_b", {16'd0, alu_b}, 32'd0);
    checkOutput("abort_alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("abort_out_result", out_result, 32'd0);
    checkOutput("abort_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_response", {31'd0, out_valid}, 32'd0);
      checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
